spi_tx_feeder: RTL and testbench
================================

SPI_TX_FEEDER -- requirements
Module: spi_tx_feeder

Interface
REQ-001 SHALL have parameter DEPTH, default 8, giving FIFO depth in bytes; legal values are powers of two, 2 to 64.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port wr_en, input, 1 bit: write request; high for one clk cycle per byte.
REQ-005 SHALL have port wr_data, input, 8 bits: byte to queue.
REQ-006 SHALL have port full, output, 1 bit: high when level equals DEPTH.
REQ-007 SHALL have port empty, output, 1 bit: high when level equals 0.
REQ-008 SHALL have port level, output, $clog2(DEPTH)+1 bits: number of bytes held in the FIFO.
REQ-009 SHALL have port tx_done, input, 1 bit: one-cycle pulse from the SPI master when the current byte has been shifted out.
REQ-010 SHALL have port tx_enable, output, 1 bit: one-cycle start pulse to the SPI master.
REQ-011 SHALL have port tx_data, output, 8 bits: byte presented to the SPI master; held stable from the tx_enable pulse until the matching tx_done.
REQ-012 SHALL have port busy, output, 1 bit: high while a byte is outstanding at the master.
REQ-013 SHALL have port ovf, output, 1 bit: sticky overflow flag (see Configuration).

Function
REQ-014 SHALL implement a circular byte FIFO of DEPTH entries, with read and write pointers that wrap from DEPTH-1 to 0.
REQ-015 SHALL accept a write when wr_en=1 and full=0, storing wr_data and incrementing level at the same clock edge.
REQ-016 SHALL also accept a write when full=1 if a pop occurs in the same cycle; level then stays at DEPTH.
REQ-017 SHALL drop any other write made while full=1, leaving FIFO contents and level unchanged.
REQ-018 SHALL implement a two-state FSM, IDLE and WAIT; the state is IDLE after reset.
REQ-019 In IDLE with empty=0, the block SHALL, at one clock edge: pop the head byte into tx_data, set tx_enable=1 and busy=1, and go to WAIT.
REQ-020 In IDLE with empty=1, the block SHALL hold tx_enable=0 and busy=0.
REQ-021 SHALL deassert tx_enable at the edge following its assertion, so the pulse is exactly one cycle wide.
REQ-022 In WAIT, the block SHALL ignore tx_done while tx_enable=1.
REQ-023 In WAIT, tx_done=1 with tx_enable=0 SHALL clear busy and return the FSM to IDLE at that edge.
REQ-024 SHALL ignore tx_done while in IDLE.
REQ-025 Latency: a write to an empty FIFO in IDLE at edge N SHALL give tx_enable=1 after edge N+1.
REQ-026 The minimum spacing between back-to-back tx_enable pulses SHALL be one cycle after tx_done (IDLE to pop).
REQ-027 On a simultaneous write and pop, level SHALL be unchanged and both pointers SHALL advance.
REQ-028 A write into an empty FIFO SHALL NOT bypass to tx_data in the same cycle; pops read only stored data.
REQ-029 SHALL compute level with no wrap; level never exceeds DEPTH and never goes below 0.

Reset
REQ-030 rst=1 SHALL immediately, without waiting for clk, clear: pointers, level (so empty=1, full=0), tx_enable, tx_data (to 8'h00), busy and ovf, and SHALL set the FSM to IDLE.
REQ-031 Reset during WAIT SHALL abandon the outstanding byte; no tx_enable pulse may follow until a new write.
REQ-032 While rst=1, the block SHALL ignore wr_en and tx_done.

Configuration
REQ-033 Macro SPI_TX_FEEDER_OVF_EN defined: a write dropped under REQ-017 SHALL set ovf=1, and ovf SHALL hold until rst.
REQ-034 Macro SPI_TX_FEEDER_OVF_EN undefined: the ovf port SHALL remain present and be driven constant 0, with no overflow logic synthesised.

Verification
REQ-035 Single byte: after reset, write 8'hA5 -> level=1 for one cycle; tx_enable pulses one cycle, 2 edges after the write; tx_data=8'hA5; busy=1 until tx_done is pulsed, then busy=0 and empty=1.
REQ-036 Ordered burst: write 8'h01..8'h04 back-to-back, with the master model pulsing tx_done 16 cycles after each tx_enable -> exactly four tx_enable pulses with tx_data 01,02,03,04 in order, each one cycle after the preceding tx_done edge.
REQ-037 Full/overflow (DEPTH=8, macro defined): hold tx_done=0 and write 10 bytes -> first pops immediately, level reaches 8 with full=1, the 10th byte is dropped and ovf=1; after rst, ovf=0. With the macro undefined, ovf stays 0 throughout.
REQ-038 Wrap and simultaneous write/pop: run 20 bytes through the DEPTH=8 FIFO with a write coinciding with a pop while full -> level stays 8 on that edge; all 20 bytes are delivered in order.
REQ-039 Mid-operation reset: assert rst asynchronously between clk edges while in WAIT with 3 bytes queued -> outputs clear before the next clk edge; no tx_enable after rst deasserts until a new write; a stray tx_done after reset has no effect.

Source files
------------

// File: rtl/spi_tx_feeder.sv
// Byte FIFO feeding an SPI master one byte per tx_enable/tx_done handshake.
// Define SPI_TX_FEEDER_OVF_EN to build the sticky overflow flag; otherwise ovf is tied low.
module spi_tx_feeder #(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [7:0]                 wr_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level,
    input  logic                       tx_done,
    output logic                       tx_enable,
    output logic [7:0]                 tx_data,
    output logic                       busy,
    output logic                       ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t          state, state_nx;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wptr, rptr;
    logic [LW-1:0]   cnt;
    logic            push, pop;
    logic            en_nx, busy_nx;

    assign full  = (cnt == LW'(DEPTH));
    assign empty = (cnt == '0);
    assign level = cnt;

    // A pop frees a slot in the same edge, so a full FIFO still takes a write then.
    assign push = wr_en && (!full || pop);

    always_comb begin
        state_nx = state;
        en_nx    = 1'b0;
        busy_nx  = busy;
        pop      = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    pop      = 1'b1;
                    en_nx    = 1'b1;
                    busy_nx  = 1'b1;
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                if (tx_done && !tx_enable) begin
                    busy_nx  = 1'b0;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            tx_enable <= 1'b0;
            busy      <= 1'b0;
            tx_data   <= 8'h00;
        end else begin
            state     <= state_nx;
            tx_enable <= en_nx;
            busy      <= busy_nx;
            if (pop) tx_data <= mem[rptr];
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) mem[wptr] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            if (push && !pop)      cnt <= cnt + 1'b1;
            else if (pop && !push) cnt <= cnt - 1'b1;
        end
    end

`ifdef SPI_TX_FEEDER_OVF_EN
    logic ovf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        ovf_q <= 1'b0;
        else if (wr_en && full && !pop) ovf_q <= 1'b1;
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_spi_tx_feeder.sv
// Scoreboard bench for spi_tx_feeder: directed writes, master model, byte-order monitor.
module tb_spi_tx_feeder;

    localparam int DEPTH = 8;
    localparam int LW    = $clog2(DEPTH) + 1;
`ifdef SPI_TX_FEEDER_OVF_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [7:0]    wr_data = 8'h00;
    logic          full, empty, tx_enable, busy, ovf;
    logic [LW-1:0] level;
    logic [7:0]    tx_data;
    logic          tx_done;
    logic          m_done = 1'b0;
    logic          d_done = 1'b0;

    assign tx_done = m_done | d_done;

    spi_tx_feeder #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .empty(empty), .level(level),
        .tx_done(tx_done), .tx_enable(tx_enable), .tx_data(tx_data),
        .busy(busy), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q[$];
    int   n_pulses = 0;
    int   gap_base = 0;
    logic gap_chk = 1'b0;
    logic auto_done = 1'b0;
    int   dly = 16;
    logic prev_en = 1'b0;
    logic d1 = 1'b0;
    logic d2 = 1'b0;

    function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endfunction

    // Monitor: every tx_enable pulse must carry the next expected byte.
    always @(negedge clk) begin
        if (tx_enable) begin
            n_pulses++;
            check("pulse_width", {31'd0, prev_en}, 0);
            check("busy_with_en", {31'd0, busy}, 1);
            if (exp_q.size() == 0) begin
                check("tx_unexpected", 1, 0);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                check("tx_data", {24'd0, tx_data}, {24'd0, e});
            end
            if (gap_chk && n_pulses > gap_base + 1)
                check("tx_gap", {31'd0, d2}, 1);
        end
        prev_en = tx_enable;
        d2 = d1;
        d1 = tx_done;
    end

    // SPI master model: answers each tx_enable after dly cycles.
    initial forever begin
        @(negedge clk);
        if (auto_done && tx_enable) begin
            repeat (dly) @(posedge clk);
            #1 m_done = 1'b1;
            @(posedge clk);
            #1 m_done = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic wr(input logic [7:0] b, input logic accept);
        wr_en = 1'b1;
        wr_data = b;
        if (accept) exp_q.push_back(b);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic drain();
        int i;
        for (i = 0; i < 3000 && !(exp_q.size() == 0 && !busy && empty); i++)
            tick();
        check("drain_timeout", {31'd0, exp_q.size() == 0 && !busy}, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        tick();
        tick();
        check("rst_empty", {31'd0, empty}, 1);
        check("rst_full", {31'd0, full}, 0);
        check("rst_level", {28'd0, level}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_txen", {31'd0, tx_enable}, 0);
        check("rst_txdata", {24'd0, tx_data}, 0);
        check("rst_ovf", {31'd0, ovf}, 0);
        rst = 1'b0;
        tick();

        // Single byte, tx_done ignored while tx_enable is high.
        wr_en = 1'b1;
        wr_data = 8'hA5;
        exp_q.push_back(8'hA5);
        tick();
        wr_en = 1'b0;
        check("sb_level1", {28'd0, level}, 1);
        check("sb_en_early", {31'd0, tx_enable}, 0);
        tick();
        check("sb_en", {31'd0, tx_enable}, 1);
        check("sb_data", {24'd0, tx_data}, 32'hA5);
        check("sb_busy", {31'd0, busy}, 1);
        check("sb_level0", {28'd0, level}, 0);
        d_done = 1'b1;
        tick();
        d_done = 1'b0;
        check("sb_en_off", {31'd0, tx_enable}, 0);
        check("sb_done_ignored", {31'd0, busy}, 1);
        d_done = 1'b1;
        tick();
        d_done = 1'b0;
        check("sb_busy_clr", {31'd0, busy}, 0);
        check("sb_empty", {31'd0, empty}, 1);
        d_done = 1'b1;
        tick();
        d_done = 1'b0;
        tick();
        check("idle_done_ignored", {31'd0, busy | tx_enable}, 0);

        // Ordered burst with spacing check.
        auto_done = 1'b1;
        dly = 16;
        gap_base = n_pulses;
        gap_chk = 1'b1;
        for (int i = 1; i <= 4; i++) wr(8'(i), 1'b1);
        drain();
        check("burst_count", n_pulses - gap_base, 4);
        gap_chk = 1'b0;
        auto_done = 1'b0;

        // Full / overflow.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            wr(8'h10 + 8'(i), i < 9);
            if (i == 8) begin
                check("full_level", {28'd0, level}, 8);
                check("full_flag", {31'd0, full}, 1);
                check("full_no_ovf", {31'd0, ovf}, 0);
            end
        end
        check("drop_level", {28'd0, level}, 8);
        check("drop_ovf", {31'd0, ovf}, {31'd0, OVF_ON});
        tick();
        tick();
        check("ovf_sticky", {31'd0, ovf}, {31'd0, OVF_ON});
        do_reset();
        check("ovf_rst", {31'd0, ovf}, 0);
        check("ovf_rst_empty", {31'd0, empty}, 1);

        // Wrap plus simultaneous write/pop while full.
        base = n_pulses;
        for (int i = 1; i <= 9; i++) wr(8'h20 + 8'(i), 1'b1);
        check("wrap_full", {28'd0, level}, 8);
        d_done = 1'b1;
        tick();
        d_done = 1'b0;
        check("wrap_idle", {31'd0, busy}, 0);
        wr_en = 1'b1;
        wr_data = 8'h2A;
        exp_q.push_back(8'h2A);
        tick();
        wr_en = 1'b0;
        check("wrap_level_hold", {28'd0, level}, 8);
        check("wrap_pop_en", {31'd0, tx_enable}, 1);
        check("wrap_no_ovf", {31'd0, ovf}, 0);
        auto_done = 1'b1;
        dly = 2;
        for (int i = 11; i <= 20; i++) begin
            for (int k = 0; k < 200 && full; k++) tick();
            check("wrap_full_wait", {31'd0, full}, 0);
            wr(8'h20 + 8'(i), 1'b1);
        end
        drain();
        check("wrap_count", n_pulses - base, 20);
        auto_done = 1'b0;

        // Asynchronous reset in WAIT with bytes queued.
        do_reset();
        for (int i = 1; i <= 4; i++) wr(8'h40 + 8'(i), 1'b1);
        tick();
        check("mr_busy", {31'd0, busy}, 1);
        check("mr_level", {28'd0, level}, 3);
        #2 rst = 1'b1;
        #1;
        check("mr_async_level", {28'd0, level}, 0);
        check("mr_async_busy", {31'd0, busy}, 0);
        check("mr_async_data", {24'd0, tx_data}, 0);
        check("mr_async_empty", {31'd0, empty}, 1);
        exp_q.delete();
        wr_en = 1'b1;
        wr_data = 8'h77;
        d_done = 1'b1;
        tick();
        wr_en = 1'b0;
        d_done = 1'b0;
        check("mr_ignore_wr", {28'd0, level}, 0);
        #2 rst = 1'b0;
        base = n_pulses;
        tick();
        tick();
        d_done = 1'b1;
        tick();
        d_done = 1'b0;
        repeat (5) tick();
        check("mr_no_pulse", n_pulses - base, 0);
        check("mr_idle", {31'd0, busy | tx_enable}, 0);
        auto_done = 1'b1;
        dly = 3;
        wr(8'h55, 1'b1);
        drain();
        check("mr_new_pulse", n_pulses - base, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
